branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/register datapath width (valid range 16..32).
REQ-002 SHALL have parameter PC_OFFSET, default 8, meaning pipeline PC-ahead added to a taken branch target.
REQ-003 SHALL have parameter REG_LAT, default 1, meaning cycles from read_en to a valid read_value (range 1..3).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request strobe, accepted only in IDLE.
- instr  in  32  instruction word, sampled with start.
- flags  in  4  NZCV as [3:0]=N,Z,C,V, sampled with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- taken  out  1  branch-taken result, valid while done=1.
- read_en  out  1  register-file read strobe, one cycle per read.
- read_reg  out  4  register index for the read.
- read_value  in  ADDR_W  read data.
- write_en  out  1  register-file write strobe, one cycle per write.
- write_reg  out  4  register index for the write.
- write_value  out  ADDR_W  write data.
- thumb  out  1  state bit from BX, valid while done=1 (present only with BRANCH_BX_EN).

Function
REQ-006 SHALL decode B/BL when instr[27:25]=101, with link=instr[24] and offset=instr[23:0].
REQ-007 SHALL evaluate cond=instr[31:28] from the sampled flags:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; 1111 0.
REQ-008 SHALL use FSM states IDLE, RD_PC, WAIT_PC, RD_RM, WAIT_RM, WR_LR, WR_PC, with transitions as follows:
- IDLE->RD_PC on start.
- RD_PC->WAIT_PC.
- WAIT_PC (REG_LAT cycles) -> WR_LR if taken&link, else RD_RM if taken BX, else WR_PC.
- RD_RM->WAIT_RM (REG_LAT) -> WR_PC.
- WR_LR->WR_PC.
- WR_PC->IDLE.
REQ-009 SHALL assert read_en=1, read_reg=15 for exactly the RD_PC cycle, and SHALL capture pc=read_value REG_LAT cycles later.
REQ-010 SHALL, in WR_LR, assert write_en=1, write_reg=14, write_value=pc+4 for one cycle.
REQ-011 SHALL, in WR_PC, assert write_en=1, write_reg=15, done=1, and taken for one cycle.
REQ-012 SHALL compute the WR_PC value as follows:
- taken B/BL: pc+PC_OFFSET+(sign-extended offset<<2).
- not taken or undecoded: pc+4.
REQ-013 SHALL perform all arithmetic modulo 2^ADDR_W, truncating the sign-extended offset to ADDR_W bits with no overflow flag.
REQ-014 SHALL NOT write r14 for a not-taken BL.
REQ-015 SHALL ignore start while not in IDLE, and SHALL sample instr/flags only in the accepting cycle.
REQ-016 SHALL give B latency start-to-done 2+REG_LAT cycles, BL 3+REG_LAT, and BX 3+2*REG_LAT.
REQ-017 SHALL accept start in the same cycle a preceding done is high (back-to-back, FSM back in IDLE).

Reset
REQ-018 SHALL, on rst=1 at a clock edge, enter IDLE and drive busy, done, taken, read_en, write_en, and thumb to 0, and read_reg, write_reg, and write_value to 0.
REQ-019 SHALL, on rst mid-operation, abort with no further writes; a WR_LR already issued is not undone.
REQ-020 SHALL give rst priority over start in the same cycle.

Configuration
REQ-021 SHALL, with macro BRANCH_BX_EN defined, decode BX as instr[27:4]=0x12FFF1 with Rm=instr[3:0].
- Taken path: RD_RM reads Rm.
- WR_PC writes Rm value with bit0 cleared.
- thumb=Rm[0].
REQ-022 SHALL, without BRANCH_BX_EN, omit the thumb port and the RD_RM/WAIT_RM states, and SHALL treat a BX encoding as undecoded (pc+4, taken=0).

Verification
REQ-023 SHALL cover taken B: REG_LAT=1, pc=0x00001000, instr=0xEA000010 -> r15=0x00001048 at start+3, taken=1, no r14 write.
REQ-024 SHALL cover taken BL backward: pc=0x00001000, instr=0xEBFFFFFE -> r14=0x00001004, then r15=0x00001000 the next cycle, done with r15 write.
REQ-025 SHALL cover not-taken BL: instr=0x0B000004, flags Z=0 -> single write r15=0x00001004, taken=0, no r14 write.
REQ-026 SHALL cover wrap-around: pc=0xFFFFFFFC, instr=0xEA000000 -> r15=0x00000004.
REQ-027 SHALL cover BX with BRANCH_BX_EN: r3=0x00002001, instr=0xE12FFF13 -> r15=0x00002000, thumb=1, taken=1, and the same stimulus without the macro -> r15=pc+4, taken=0.
REQ-028 SHALL cover reset mid-BL: rst asserted in WR_LR cycle -> no r15 write, all outputs 0 next cycle, and a following start runs normally.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: sequential branch executor for B/BL (and BX when BRANCH_BX_EN is defined).
// Reads r15 through a fixed-latency register-file port, evaluates the condition
// code against the flags captured at start, optionally writes the link register,
// and finally writes the new PC with a one-cycle done pulse.
//
// Optional feature macro: BRANCH_BX_EN (adds BX decode, RD_RM/WAIT_RM states, thumb port).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, instr, flags request strobe with instruction word and NZCV flags
//   busy, done, taken   status: busy through done, one-cycle done, branch result
//   read_en/read_reg    register read strobe/index; read_value returns REG_LAT cycles later
//   write_en/write_reg/write_value  register write strobe/index/data
//   thumb               BX state bit, valid while done (BRANCH_BX_EN only)
module branch_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned PC_OFFSET = 8,
    parameter int unsigned REG_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic [3:0]        flags,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              read_en,
    output logic [3:0]        read_reg,
    input  logic [ADDR_W-1:0] read_value,
    output logic              write_en,
    output logic [3:0]        write_reg,
    output logic [ADDR_W-1:0] write_value
`ifdef BRANCH_BX_EN
    ,
    output logic              thumb
`endif
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned EXT_W = (ADDR_W > 26) ? ADDR_W : 26;
    localparam logic [3:0]  PC_REG = 4'd15;
    localparam logic [3:0]  LR_REG = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_PC   = 3'd1,
        S_WAIT_PC = 3'd2,
`ifdef BRANCH_BX_EN
        S_RD_RM   = 3'd3,
        S_WAIT_RM = 3'd4,
`endif
        S_WR_LR   = 3'd5,
        S_WR_PC   = 3'd6
    } state_t;

    // Condition-code evaluation; flags are {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = cf;
            4'h3:    cond_eval = !cf;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = cf && !z;
            4'h9:    cond_eval = !cf || z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z && (n == v);
            4'hD:    cond_eval = z || (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               cond_ok_q, cond_ok_d;
    logic               is_b_q, is_b_d;
    logic               link_q, link_d;
    logic [23:0]        offset_q, offset_d;
`ifdef BRANCH_BX_EN
    logic               is_bx_q, is_bx_d;
    logic [3:0]         rm_idx_q, rm_idx_d;
    logic               thumb_q, thumb_d;
`endif

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               taken_q, taken_d;
    logic               read_en_q, read_en_d;
    logic [3:0]         read_reg_q, read_reg_d;
    logic               write_en_q, write_en_d;
    logic [3:0]         write_reg_q, write_reg_d;
    logic [ADDR_W-1:0]  write_value_q, write_value_d;

    logic               accept_c;
    logic               taken_c;
    logic               wait_last_c;
    logic [EXT_W-1:0]   off_ext_c;
    logic [ADDR_W-1:0]  target_c;

    // State, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pc_q          <= '0;
            cond_ok_q     <= 1'b0;
            is_b_q        <= 1'b0;
            link_q        <= 1'b0;
            offset_q      <= '0;
`ifdef BRANCH_BX_EN
            is_bx_q       <= 1'b0;
            rm_idx_q      <= '0;
            thumb_q       <= 1'b0;
`endif
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
            read_en_q     <= 1'b0;
            read_reg_q    <= '0;
            write_en_q    <= 1'b0;
            write_reg_q   <= '0;
            write_value_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            cond_ok_q     <= cond_ok_d;
            is_b_q        <= is_b_d;
            link_q        <= link_d;
            offset_q      <= offset_d;
`ifdef BRANCH_BX_EN
            is_bx_q       <= is_bx_d;
            rm_idx_q      <= rm_idx_d;
            thumb_q       <= thumb_d;
`endif
            busy_q        <= busy_d;
            done_q        <= done_d;
            taken_q       <= taken_d;
            read_en_q     <= read_en_d;
            read_reg_q    <= read_reg_d;
            write_en_q    <= write_en_d;
            write_reg_q   <= write_reg_d;
            write_value_q <= write_value_d;
        end
    end

    // Next state, request capture, and outputs decoded from the next state so
    // each strobe is high for exactly the cycle spent in its state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        cond_ok_d     = cond_ok_q;
        is_b_d        = is_b_q;
        link_d        = link_q;
        offset_d      = offset_q;
`ifdef BRANCH_BX_EN
        is_bx_d       = is_bx_q;
        rm_idx_d      = rm_idx_q;
        thumb_d       = 1'b0;
        taken_c       = cond_ok_q && (is_b_q || is_bx_q);
`else
        taken_c       = cond_ok_q && is_b_q;
`endif
        busy_d        = 1'b0;
        done_d        = 1'b0;
        taken_d       = 1'b0;
        read_en_d     = 1'b0;
        read_reg_d    = '0;
        write_en_d    = 1'b0;
        write_reg_d   = '0;
        write_value_d = '0;

        // The done cycle also accepts, giving back-to-back operation.
        accept_c    = start && ((state_q == S_IDLE) || (state_q == S_WR_PC));
        wait_last_c = (cnt_q == CNT_W'(REG_LAT - 1));

        case (state_q)
            S_IDLE: ;
            S_RD_PC: begin
                state_d = S_WAIT_PC;
                cnt_d   = '0;
            end
            S_WAIT_PC: begin
                if (wait_last_c) begin
                    pc_d = read_value;
                    if (taken_c && link_q && is_b_q) begin
                        state_d = S_WR_LR;
`ifdef BRANCH_BX_EN
                    end else if (taken_c && is_bx_q) begin
                        state_d = S_RD_RM;
`endif
                    end else begin
                        state_d = S_WR_PC;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef BRANCH_BX_EN
            S_RD_RM: begin
                state_d = S_WAIT_RM;
                cnt_d   = '0;
            end
            S_WAIT_RM: begin
                if (wait_last_c) begin
                    state_d = S_WR_PC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_WR_LR: state_d = S_WR_PC;
            S_WR_PC: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept_c) begin
            state_d   = S_RD_PC;
            cond_ok_d = cond_eval(instr[31:28], flags);
            is_b_d    = (instr[27:25] == 3'b101);
            link_d    = instr[24];
            offset_d  = instr[23:0];
`ifdef BRANCH_BX_EN
            is_bx_d   = (instr[27:4] == 24'h12FFF1);
            rm_idx_d  = instr[3:0];
`endif
        end

        // Word offset, sign-extended then wrapped to the datapath width.
        off_ext_c = EXT_W'($signed({offset_q, 2'b00}));
        target_c  = pc_d + ADDR_W'(PC_OFFSET) + ADDR_W'(off_ext_c);

        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_RD_PC: begin
                read_en_d  = 1'b1;
                read_reg_d = PC_REG;
            end
`ifdef BRANCH_BX_EN
            S_RD_RM: begin
                read_en_d  = 1'b1;
                read_reg_d = rm_idx_q;
            end
`endif
            S_WR_LR: begin
                write_en_d    = 1'b1;
                write_reg_d   = LR_REG;
                write_value_d = pc_d + ADDR_W'(4);
            end
            S_WR_PC: begin
                write_en_d  = 1'b1;
                write_reg_d = PC_REG;
                done_d      = 1'b1;
                taken_d     = taken_c;
                if (taken_c && is_b_q) begin
                    write_value_d = target_c;
`ifdef BRANCH_BX_EN
                end else if (taken_c && is_bx_q) begin
                    // Rm value arrives on read_value in the last WAIT_RM cycle.
                    write_value_d = {read_value[ADDR_W-1:1], 1'b0};
                    thumb_d       = read_value[0];
`endif
                end else begin
                    write_value_d = pc_d + ADDR_W'(4);
                end
            end
            default: ;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign taken       = taken_q;
    assign read_en     = read_en_q;
    assign read_reg    = read_reg_q;
    assign write_en    = write_en_q;
    assign write_reg   = write_reg_q;
    assign write_value = write_value_q;
`ifdef BRANCH_BX_EN
    assign thumb       = thumb_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vectors, reset cases and
// randomized operations checked cycle by cycle against a behavioural model.
module tb_branch_unit;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned PC_OFFSET = 8;
    localparam int unsigned REG_LAT   = 1;
`ifdef BRANCH_BX_EN
    localparam bit BX_EN = 1'b1;
`else
    localparam bit BX_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       instr;
    logic [3:0]        flags;
    logic              busy, done, taken, read_en, write_en;
    logic [3:0]        read_reg, write_reg;
    logic [ADDR_W-1:0] read_value, write_value;
`ifdef BRANCH_BX_EN
    logic              thumb;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] regs [16];
    logic [31:0] rd_pipe [REG_LAT];

    always #5 clk = ~clk;

    branch_unit #(
        .ADDR_W(ADDR_W), .PC_OFFSET(PC_OFFSET), .REG_LAT(REG_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .flags(flags),
        .busy(busy), .done(done), .taken(taken),
        .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value)
`ifdef BRANCH_BX_EN
        , .thumb(thumb)
`endif
    );

    // Register file with REG_LAT-cycle read latency; idle slots return junk.
    always @(posedge clk) begin
        rd_pipe[0] <= read_en ? regs[read_reg] : 32'hDEAD_BEEF;
        for (int i = 1; i < REG_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_value = rd_pipe[REG_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            0: return z;           1: return !z;
            2: return cf;          3: return !cf;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return cf && !z;    9: return !cf || z;
            10: return n == v;     11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " read_en"}, 32'(read_en), 0);
        chk({tag, " write_en"}, 32'(write_en), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check_quiet("idle");
            instr = $urandom;
            flags = 4'($urandom);
        end
    endtask

    // Called at a negedge with the DUT idle or in its done cycle; returns at
    // the negedge of the done cycle with start low.
    task automatic run_op(input logic [31:0] ins, input logic [3:0] fl);
        logic [31:0] pc, tgt, lr_val;
        bit          is_b, is_bx, tk, thb;
        int          lat, lr_cyc, rm_cyc, off;
        logic [3:0]  rm;
        pc     = regs[15];
        is_b   = (ins[27:25] == 3'b101);
        is_bx  = BX_EN && (ins[27:4] == 24'h12FFF1);
        tk     = cond_true(ins[31:28], fl) && (is_b || is_bx);
        rm     = ins[3:0];
        off    = int'($signed(ins[23:0]));
        lr_cyc = 0;
        rm_cyc = 0;
        lr_val = pc + 32'd4;
        thb    = 1'b0;
        lat    = 2 + REG_LAT;
        tgt    = pc + 32'd4;
        if (tk && is_b) begin
            tgt = pc + 32'(PC_OFFSET) + 32'(off * 4);
            if (ins[24]) begin
                lr_cyc = 2 + REG_LAT;
                lat    = 3 + REG_LAT;
            end
        end else if (tk && is_bx) begin
            rm_cyc = 2 + REG_LAT;
            lat    = 3 + 2 * REG_LAT;
            tgt    = regs[rm] & ~32'd1;
            thb    = regs[rm][0];
        end

        start = 1'b1;
        instr = ins;
        flags = fl;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 1);
            chk("read_en", 32'(read_en), 32'((c == 1) || (c == rm_cyc)));
            if (c == 1) chk("read_reg pc", 32'(read_reg), 15);
            if (c == rm_cyc) chk("read_reg rm", 32'(read_reg), 32'(rm));
            chk("write_en", 32'(write_en), 32'((c == lr_cyc) || (c == lat)));
            if (c == lr_cyc) begin
                chk("lr write_reg", 32'(write_reg), 14);
                chk("lr write_value", write_value, lr_val);
            end
            chk("done", 32'(done), 32'(c == lat));
            if (c == lat) begin
                chk("pc write_reg", 32'(write_reg), 15);
                chk("pc write_value", write_value, tgt);
                chk("taken", 32'(taken), 32'(tk));
`ifdef BRANCH_BX_EN
                if (tk && is_bx) chk("thumb", 32'(thumb), 32'(thb));
`endif
            end
            // Starts while busy must be ignored; the done cycle would accept one.
            start = (c < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            instr = $urandom;
            flags = 4'($urandom);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [1:0]  kind;
        for (int i = 0; i < 16; i++) regs[i] = 32'h100 * i;
        rst   = 1'b1;
        start = 1'b0;
        instr = '0;
        flags = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst taken", 32'(taken), 0);
        chk("rst read_en", 32'(read_en), 0);
        chk("rst read_reg", 32'(read_reg), 0);
        chk("rst write_en", 32'(write_en), 0);
        chk("rst write_reg", 32'(write_reg), 0);
        chk("rst write_value", write_value, 0);
`ifdef BRANCH_BX_EN
        chk("rst thumb", 32'(thumb), 0);
`endif
        rst = 1'b0;
        idle(2);

        // Directed vectors.
        regs[15] = 32'h0000_1000;
        run_op(32'hEA00_0010, 4'h0);           // taken B -> 0x1048
        run_op(32'h0B00_0004, 4'h0);           // back-to-back, not-taken BL (Z=0)
        idle(1);
        run_op(32'hEBFF_FFFE, 4'h0);           // taken BL backward
        idle(1);
        regs[15] = 32'hFFFF_FFFC;
        run_op(32'hEA00_0000, 4'h0);           // wrap-around -> 0x4
        idle(1);
        regs[15] = 32'h0000_1000;
        regs[3]  = 32'h0000_2001;
        run_op(32'hE12F_FF13, 4'h0);           // BX r3 (undecoded without the macro)
        idle(1);
        run_op(32'h1A00_0003, 4'h4);           // NE with Z=1: not taken
        idle(1);

        // Reset during the WR_LR cycle of a taken BL.
        start = 1'b1;
        instr = 32'hEB00_0002;
        flags = 4'h0;
        for (int c = 1; c <= 2 + REG_LAT; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2 + REG_LAT) begin
                chk("mid lr write_en", 32'(write_en), 1);
                chk("mid lr write_reg", 32'(write_reg), 14);
                chk("mid lr write_value", write_value, 32'h0000_1004);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        check_quiet("after rst");
        chk("after rst taken", 32'(taken), 0);
        chk("after rst write_reg", 32'(write_reg), 0);
        chk("after rst write_value", write_value, 0);
        rst = 1'b0;
        idle(2);
        run_op(32'hEA00_0010, 4'h0);
        idle(1);

        // Reset has priority over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        instr = 32'hEA00_0010;
        @(negedge clk);
        check_quiet("rst vs start");
        rst   = 1'b0;
        start = 1'b0;
        idle(2);

        // Randomized operations.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            kind = 2'($urandom_range(0, 3));
            ins  = $urandom;
            if (kind <= 1) ins[27:25] = 3'b101;
            else if (kind == 2) ins[27:4] = 24'h12FFF1;
            run_op(ins, 4'($urandom));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
